// File: rtl/i2c_wiper_target.sv
// I2C target emulating a single-register digital potentiometer.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_wiper_target #(
  parameter logic [6:0] ADDR        = 7'h2F,
  parameter logic [7:0] WIPER_MAX   = 8'd127,
  parameter logic [7:0] WIPER_RESET = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] wiper,
  output logic       wr_strobe,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  logic   scl_meta_r, scl_sync_r, scl_prev_r;
  logic   sda_meta_r, sda_sync_r, sda_prev_r;
  logic   scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r, state_s;
  logic [7:0] shift_r, shift_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic       phase_r, phase_s;
  logic       rw_r, rw_s;
  logic       sda_oe_r, sda_oe_s;
  logic [7:0] wiper_r, wiper_s;
  logic       wr_strobe_r, wr_strobe_s;
  logic       busy_r, busy_s;
  logic [7:0] rx_byte_s;

  function automatic logic [7:0] clamp_wiper(input logic [7:0] value);
    if (value > WIPER_MAX) begin
      return WIPER_MAX;
    end else begin
      return value;
    end
  endfunction

  // Pad synchronizers keep tracking the bus through reset so no false edges appear afterwards
  always_ff @(posedge clk) begin
    scl_meta_r <= scl_in;
    scl_sync_r <= scl_meta_r;
    scl_prev_r <= scl_sync_r;
    sda_meta_r <= sda_in;
    sda_sync_r <= sda_meta_r;
    sda_prev_r <= sda_sync_r;
  end

  assign scl_rise_s = scl_sync_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_sync_r & scl_prev_r;
  assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
  assign rx_byte_s  = {shift_r[6:0], sda_sync_r};

  // State and datapath register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'd0;
      bit_cnt_r   <= 3'd0;
      phase_r     <= 1'b0;
      rw_r        <= 1'b0;
      sda_oe_r    <= 1'b0;
      wiper_r     <= WIPER_RESET;
      wr_strobe_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      phase_r     <= phase_s;
      rw_r        <= rw_s;
      sda_oe_r    <= sda_oe_s;
      wiper_r     <= wiper_s;
      wr_strobe_r <= wr_strobe_s;
      busy_r      <= busy_s;
    end
  end

  // Next-state and output logic; phase_r marks the second half of ACK handling
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    phase_s     = phase_r;
    rw_s        = rw_r;
    sda_oe_s    = sda_oe_r;
    wiper_s     = wiper_r;
    wr_strobe_s = 1'b0;
    busy_s      = busy_r;

    if (start_s) begin
      state_s   = ST_ADDR;
      shift_s   = 8'd0;
      bit_cnt_s = 3'd0;
      phase_s   = 1'b0;
      sda_oe_s  = 1'b0;
      busy_s    = 1'b1;
    end else if (stop_s) begin
      state_s   = ST_IDLE;
      bit_cnt_s = 3'd0;
      phase_s   = 1'b0;
      sda_oe_s  = 1'b0;
      busy_s    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sda_oe_s = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_s   = rx_byte_s;
            bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              rw_s    = rx_byte_s[0];
              phase_s = 1'b0;
              if (rx_byte_s[7:1] == ADDR) begin
                state_s = ST_ADDR_ACK;
              end else begin
                state_s = ST_WAIT_STOP;
              end
            end else begin
              state_s = ST_ADDR;
            end
          end else begin
            state_s = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!phase_r) begin
              sda_oe_s = 1'b1;
              phase_s  = 1'b1;
            end else begin
              phase_s   = 1'b0;
              bit_cnt_s = 3'd0;
              if (rw_r) begin
                // First read bit goes out on the same fall that ends the ACK
                shift_s  = wiper_r;
                sda_oe_s = ~wiper_r[7];
                state_s  = ST_READ;
              end else begin
                sda_oe_s = 1'b0;
                state_s  = ST_WRITE;
              end
            end
          end else begin
            state_s = ST_ADDR_ACK;
          end
        end
        ST_WRITE: begin
          if (scl_rise_s) begin
            shift_s   = rx_byte_s;
            bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              phase_s = 1'b0;
              state_s = ST_WRITE_ACK;
            end else begin
              state_s = ST_WRITE;
            end
          end else begin
            state_s = ST_WRITE;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall_s) begin
            if (!phase_r) begin
              sda_oe_s = 1'b1;
              phase_s  = 1'b1;
            end else begin
              sda_oe_s    = 1'b0;
              phase_s     = 1'b0;
              bit_cnt_s   = 3'd0;
              wiper_s     = clamp_wiper(shift_r);
              wr_strobe_s = 1'b1;
              state_s     = ST_WRITE;
            end
          end else begin
            state_s = ST_WRITE_ACK;
          end
        end
        ST_READ: begin
          if (scl_rise_s) begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_r == 3'd0) begin
              sda_oe_s = 1'b0;
              phase_s  = 1'b0;
              state_s  = ST_READ_ACK;
            end else begin
              shift_s  = {shift_r[6:0], 1'b0};
              sda_oe_s = ~shift_r[6];
            end
          end else begin
            state_s = ST_READ;
          end
        end
        ST_READ_ACK: begin
          if (scl_rise_s) begin
            if (sda_sync_r) begin
              sda_oe_s = 1'b0;
              state_s  = ST_WAIT_STOP;
            end else begin
              phase_s = 1'b1;
            end
          end else if (scl_fall_s && phase_r) begin
            shift_s   = wiper_r;
            sda_oe_s  = ~wiper_r[7];
            bit_cnt_s = 3'd0;
            phase_s   = 1'b0;
            state_s   = ST_READ;
          end else begin
            state_s = ST_READ_ACK;
          end
        end
        ST_WAIT_STOP: begin
          sda_oe_s = 1'b0;
        end
        default: begin
          state_s  = ST_IDLE;
          sda_oe_s = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_r;
  assign wiper     = wiper_r;
  assign wr_strobe = wr_strobe_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_wiper_target.sv
// Directed bench for i2c_wiper_target: a bit-banged I2C initiator over an open-drain SDA model.
`timescale 1ns/1ps
module tb_i2c_wiper_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] wiper;
  logic       wr_strobe;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int oe_cnt = 0;
  int strobe_cnt = 0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_wiper_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .wiper     (wiper),
    .wr_strobe (wr_strobe),
    .busy      (busy)
  );

  always #31 clk = ~clk;

  always @(posedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    sda_m = b; q();
    scl_m = 1'b1; q();
    sampled = sda_bus; q();
    scl_m = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s0;
    int         o0;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_wiper", wiper, 8'h00);
    check("reset_wr_strobe", wr_strobe, 0);
    check("reset_busy", busy, 0);

    // simple write of 10
    s0 = strobe_cnt;
    bus_start();
    check("t1_busy_after_start", busy, 1);
    write_byte(8'h5E, ack); check("t1_addr_ack", ack, 0);
    write_byte(8'h0A, ack); check("t1_data_ack", ack, 0);
    check("t1_wiper", wiper, 8'h0A);
    bus_stop();
    check("t1_busy_after_stop", busy, 0);
    check("t1_strobes", strobe_cnt - s0, 1);

    // clamped write
    bus_start();
    write_byte(8'h5E, ack); check("t2_addr_ack", ack, 0);
    write_byte(8'hC8, ack); check("t2_data_ack", ack, 0);
    check("t2_wiper_clamped", wiper, 8'h7F);
    bus_stop();

    // write, repeated start, read with ACK then NACK
    bus_start();
    write_byte(8'h5E, ack); check("t3_addr_w_ack", ack, 0);
    write_byte(8'h32, ack); check("t3_data_ack", ack, 0);
    check("t3_wiper", wiper, 8'h32);
    bus_start();
    write_byte(8'h5F, ack); check("t3_addr_r_ack", ack, 0);
    read_byte(1'b0, rd); check("t3_read0", rd, 8'h32);
    read_byte(1'b1, rd); check("t3_read1", rd, 8'h32);
    check("t3_released_after_nack", sda_oe, 0);
    o0 = oe_cnt;
    write_byte(8'hFF, ack); check("t3_wait_stop_no_ack", ack, 1);
    check("t3_wait_stop_no_drive", oe_cnt - o0, 0);
    check("t3_busy_before_stop", busy, 1);
    bus_stop();
    check("t3_busy_after_stop", busy, 0);

    // wrong address
    o0 = oe_cnt;
    s0 = strobe_cnt;
    bus_start();
    write_byte(8'h5C, ack); check("t4_addr_nack", ack, 1);
    write_byte(8'h55, ack); check("t4_data_nack", ack, 1);
    bus_stop();
    check("t4_never_driven", oe_cnt - o0, 0);
    check("t4_wiper_kept", wiper, 8'h32);
    check("t4_no_strobe", strobe_cnt - s0, 0);

    // reset in the middle of a data byte
    bus_start();
    write_byte(8'h5E, ack); check("t5_addr_ack", ack, 0);
    clock_bit(1'b0, ack);
    clock_bit(1'b1, ack);
    clock_bit(1'b0, ack);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("t5_sda_oe_after_rst", sda_oe, 0);
    check("t5_wiper_after_rst", wiper, 8'h00);
    check("t5_busy_after_rst", busy, 0);
    for (int i = 0; i < 5; i++) clock_bit(1'b0, ack);
    clock_bit(1'b1, ack); check("t5_no_resync_ack", ack, 1);
    bus_stop();
    bus_start();
    write_byte(8'h5E, ack); check("t5_addr_ack2", ack, 0);
    write_byte(8'h07, ack); check("t5_data_ack2", ack, 0);
    bus_stop();
    check("t5_wiper_after_write", wiper, 8'h07);

    // multi-byte write
    s0 = strobe_cnt;
    bus_start();
    write_byte(8'h5E, ack); check("t6_addr_ack", ack, 0);
    write_byte(8'h01, ack); check("t6_ack1", ack, 0);
    check("t6_wiper1", wiper, 8'h01);
    write_byte(8'h02, ack); check("t6_ack2", ack, 0);
    write_byte(8'h03, ack); check("t6_ack3", ack, 0);
    bus_stop();
    check("t6_strobes", strobe_cnt - s0, 3);
    check("t6_wiper_final", wiper, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
